sync_pulse_ratio_tracker: RTL



---
 rtl/sync_pulse_ratio_tracker_pkg.sv | 20 ++
 rtl/sync_pulse_edge_det.sv | 26 ++
 rtl/sync_pulse_ratio_tracker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sync_pulse_ratio_tracker_pkg.sv
// Shared definitions for the pulse ratio tracker: state encoding and default sizing.
// The cluster header and the bench reuse these defaults.
package sync_pulse_ratio_tracker_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_LOCK_CNT = 3;
    localparam int unsigned DEF_LEAD     = 1;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int unsigned count_width(input int unsigned n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_pulse_edge_det.sv
// Rising-edge detector on the synchronized pulse; the history flop resets high
// so a level already high at reset release is not mistaken for an edge.
module sync_pulse_edge_det (
    input  logic rclk,
    input  logic reset,
    input  logic enable,
    input  logic sync_in,
    output logic rise_c,
    output logic edge_pulse
);

    logic sync_d;

    assign rise_c = sync_in & ~sync_d;

    always_ff @(posedge rclk) begin
        if (reset) begin
            sync_d     <= 1'b1;
            edge_pulse <= 1'b0;
        end else begin
            sync_d     <= sync_in;
            edge_pulse <= rise_c & enable;
        end
    end

endmodule

// File: rtl/sync_pulse_ratio_tracker.sv
// Measures the edge-to-edge period of the synchronized pulse, locks after a run of
// equal periods, then predicts each upcoming edge LEAD cycles ahead and flags slips.
module sync_pulse_ratio_tracker
    import sync_pulse_ratio_tracker_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned LEAD     = DEF_LEAD
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_in,
    output logic             edge_pulse,
    output logic             pred_pulse,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             err_pulse
);

    localparam int unsigned      MATCH_W = count_width(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEAD_V  = CNT_W'(LEAD);
    localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    logic rise_c;

    state_e             state_q,  state_nxt;
    logic [CNT_W-1:0]   cnt_q,    cnt_nxt;
    logic [CNT_W-1:0]   last_p_q, last_p_nxt;
    logic [MATCH_W-1:0] match_q,  match_nxt;
    logic [MATCH_W-1:0] match_res;
    logic [CNT_W-1:0]   period_nxt;
    logic               err_nxt;
    logic               pred_nxt;

    sync_pulse_edge_det u_edge_det (
        .rclk       (rclk),
        .reset      (reset),
        .enable     (enable),
        .sync_in    (sync_in),
        .rise_c     (rise_c),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q    <= ACQ;
            cnt_q      <= '0;
            last_p_q   <= '0;
            match_q    <= '0;
            period     <= '0;
            locked     <= 1'b0;
            pred_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            last_p_q   <= last_p_nxt;
            match_q    <= match_nxt;
            period     <= period_nxt;
            locked     <= (state_nxt == LOCKED);
            pred_pulse <= pred_nxt;
            err_pulse  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        last_p_nxt = last_p_q;
        match_nxt  = match_q;
        match_res  = '0;
        err_nxt    = 1'b0;
        // cnt holds cycles since the last rise, so at a rise it equals the period
        if (rise_c) begin
            cnt_nxt = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_nxt = cnt_q;
        end else begin
            cnt_nxt = cnt_q + CNT_ONE;
        end

        if (!enable) begin
            state_nxt  = ACQ;
            cnt_nxt    = '0;
            last_p_nxt = '0;
            match_nxt  = '0;
        end else begin
            case (state_q)
                ACQ: begin
                    if (rise_c) begin
                        state_nxt = MEAS;
                        match_nxt = '0;
                    end
                end
                MEAS: begin
                    if (rise_c) begin
                        if ((match_q == '0) || (cnt_q != last_p_q)) begin
                            match_res = MATCH_ONE;
                        end else begin
                            match_res = match_q + MATCH_ONE;
                        end
                        last_p_nxt = cnt_q;
                        // periods this short leave no room for the predictive lead
                        if (cnt_q <= LEAD_V) begin
                            match_nxt = MATCH_ONE;
                        end else begin
                            match_nxt = match_res;
                            if (match_res == LOCK_V) begin
                                state_nxt = LOCKED;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_nxt = ACQ;
                    end
                end
                LOCKED: begin
                    if (rise_c) begin
                        if (cnt_q != period) begin
                            err_nxt    = 1'b1;
                            state_nxt  = MEAS;
                            last_p_nxt = '0;
                            match_nxt  = '0;
                        end
                    end else if (cnt_q == period) begin
                        err_nxt   = 1'b1;
                        state_nxt = ACQ;
                    end
                end
                default: begin
                    state_nxt = ACQ;
                end
            endcase
        end

        if (state_nxt != LOCKED) begin
            period_nxt = '0;
        end else if (state_q != LOCKED) begin
            period_nxt = cnt_q;
        end else begin
            period_nxt = period;
        end

        pred_nxt = (state_nxt == LOCKED) && (cnt_nxt == (period_nxt - LEAD_V));
    end

endmodule
